// File: rtl/proc_ctrl_fsm.sv
// Control sequencer for the 16-bit simple processor: decodes IR into T0..T3 steps
// driving bus-mux select, load enables and ALU op. Optional PROC_CTRL_INSTR_CNT_EN adds instr_cnt.
module proc_ctrl_fsm #(
  parameter int SEL_W = 4,
  parameter logic [SEL_W-1:0] SEL_G  = SEL_W'(8),
  parameter logic [SEL_W-1:0] SEL_D  = SEL_W'(9),
  parameter logic [SEL_W-1:0] SEL_DT = SEL_W'(10)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      IR,
  output logic [SEL_W-1:0] s1,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic             ir_in,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [1:0]       fsm_state
`ifdef PROC_CTRL_INSTR_CNT_EN
  ,
  output logic [15:0]      instr_cnt
`endif
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;

  state_t state, next_state;

  logic [2:0]       opcode;
  logic [2:0]       rx;
  logic             imm_flag;
  logic [SEL_W-1:0] operand_sel;
  logic [7:0]       rx_onehot;
  logic             unused_ir_bits;

  assign opcode      = IR[15:13];
  assign rx          = IR[12:10];
  assign imm_flag    = IR[9];
  assign operand_sel = imm_flag ? SEL_D : SEL_W'(IR[2:0]);
  assign rx_onehot   = 8'b0000_0001 << rx;
  // IR[8:3] only matter to the datapath's immediate path, not to sequencing.
  assign unused_ir_bits = ^IR[8:3];

  assign fsm_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= T0;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    s1         = '0;
    r_in       = '0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    ir_in      = 1'b0;
    alu_op     = 2'b00;
    busy       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    // Outputs stay at defaults while reset is held so an aborted step loads nothing.
    if (!reset) begin
      case (state)
        T0: begin
          ir_in = run;
          if (run) next_state = T1;
        end
        T1: begin
          busy = 1'b1;
          case (opcode)
            OP_MV: begin
              s1         = operand_sel;
              r_in       = rx_onehot;
              done       = 1'b1;
              next_state = T0;
            end
            OP_MVT: begin
              s1         = SEL_DT;
              r_in       = rx_onehot;
              done       = 1'b1;
              next_state = T0;
            end
            OP_ADD, OP_SUB, OP_AND: begin
              s1         = SEL_W'(rx);
              a_in       = 1'b1;
              next_state = T2;
            end
            default: begin
              done       = 1'b1;
              illegal    = 1'b1;
              next_state = T0;
            end
          endcase
        end
        T2: begin
          busy = 1'b1;
          s1   = operand_sel;
          g_in = 1'b1;
          case (opcode)
            OP_SUB:  alu_op = 2'b01;
            OP_AND:  alu_op = 2'b10;
            default: alu_op = 2'b00;
          endcase
          next_state = T3;
        end
        T3: begin
          busy       = 1'b1;
          s1         = SEL_G;
          r_in       = rx_onehot;
          done       = 1'b1;
          next_state = T0;
        end
        default: next_state = T0;
      endcase
    end
  end

`ifdef PROC_CTRL_INSTR_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                instr_cnt <= 16'h0000;
    else if (done && !illegal) instr_cnt <= instr_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Scoreboard bench for proc_ctrl_fsm: driver pushes per-cycle expectations from an
// instruction-level model, a negedge monitor pops and compares.
module tb_proc_ctrl_fsm;

  typedef struct packed {
    logic [3:0] s1;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       ir_in;
    logic [1:0] alu_op;
    logic       busy;
    logic       done;
    logic       illegal;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run   = 1'b0;
  logic [15:0] IR    = 16'h0000;
  logic [3:0]  s1;
  logic [7:0]  r_in;
  logic        a_in, g_in, ir_in, busy, done, illegal;
  logic [1:0]  alu_op;
  logic [1:0]  fsm_state;
`ifdef PROC_CTRL_INSTR_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] cnt_q[$];
`endif
  logic [15:0] cnt_model = 16'h0000;

  logic [19:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  proc_ctrl_fsm dut (
    .clock(clock), .reset(reset), .run(run), .IR(IR),
    .s1(s1), .r_in(r_in), .a_in(a_in), .g_in(g_in), .ir_in(ir_in),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .fsm_state(fsm_state)
`ifdef PROC_CTRL_INSTR_CNT_EN
    , .instr_cnt(instr_cnt)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  // Instruction-level reference: list of output vectors for the steps after fetch.
  function automatic void model_steps(input logic [15:0] ir, output vec_t st [3],
                                      output int n, output logic legal);
    int         op;
    logic [7:0] dest;
    logic [3:0] operand;
    op      = int'(ir[15:13]);
    dest    = '0;
    dest[ir[12:10]] = 1'b1;
    operand = ir[9] ? 4'd9 : {1'b0, ir[2:0]};
    for (int k = 0; k < 3; k++) st[k] = '0;
    legal = (op <= 4);
    if (op == 0) begin
      n = 1;
      st[0].s1 = operand; st[0].r_in = dest; st[0].done = 1'b1;
    end else if (op == 1) begin
      n = 1;
      st[0].s1 = 4'd10; st[0].r_in = dest; st[0].done = 1'b1;
    end else if (legal) begin
      n = 3;
      st[0].s1 = {1'b0, ir[12:10]}; st[0].a_in = 1'b1;
      st[1].s1 = operand; st[1].g_in = 1'b1; st[1].alu_op = 2'(op - 2);
      st[2].s1 = 4'd8; st[2].r_in = dest; st[2].done = 1'b1;
    end else begin
      n = 1;
      st[0].done = 1'b1; st[0].illegal = 1'b1;
    end
    for (int k = 0; k < n; k++) st[k].busy = 1'b1;
  endfunction

  // driver tasks
  task automatic do_cycle(input logic rst_v, input logic run_v, input logic [15:0] ir_v,
                          input vec_t e);
    @(posedge clock);
    #1;
    reset = rst_v;
    run   = run_v;
    IR    = ir_v;
    exp_q.push_back(e);
`ifdef PROC_CTRL_INSTR_CNT_EN
    cnt_q.push_back(cnt_model);
`endif
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 1'b0, 16'($urandom), '0);
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic hold);
    vec_t st [3];
    vec_t f;
    int   n;
    logic legal;
    model_steps(ir, st, n, legal);
    f = '0;
    f.ir_in = 1'b1;
    do_cycle(1'b0, 1'b1, 16'($urandom), f);
    for (int k = 0; k < n; k++)
      do_cycle(1'b0, hold ? 1'b1 : 1'($urandom_range(0, 1)), ir, st[k]);
    if (legal) cnt_model = cnt_model + 16'd1;
  endtask

  // Reset arrives in the cycle that would have been step k+1 of the instruction.
  task automatic abort_instr(input logic [15:0] ir, input int k);
    vec_t st [3];
    vec_t f;
    int   n;
    logic legal;
    model_steps(ir, st, n, legal);
    f = '0;
    f.ir_in = 1'b1;
    do_cycle(1'b0, 1'b1, 16'($urandom), f);
    for (int j = 0; j < k && j < n; j++) begin
      do_cycle(1'b0, 1'b0, ir, st[j]);
    end
    cnt_model = 16'd0;
    do_cycle(1'b1, 1'($urandom_range(0, 1)), ir, '0);
    idle_cycle();
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    vec_t act, e;
    cycle++;
    if (exp_q.size() > 0) begin
      e   = vec_t'(exp_q.pop_front());
      act = '{s1: s1, r_in: r_in, a_in: a_in, g_in: g_in, ir_in: ir_in,
              alu_op: alu_op, busy: busy, done: done, illegal: illegal};
      checks++;
      if (act === e) passes++;
      else $display("FAIL outputs cycle=%0d IR=%h got s1=%0d r_in=%b a=%b g=%b ir=%b op=%b busy=%b done=%b ill=%b exp s1=%0d r_in=%b a=%b g=%b ir=%b op=%b busy=%b done=%b ill=%b",
                    cycle, IR, act.s1, act.r_in, act.a_in, act.g_in, act.ir_in, act.alu_op,
                    act.busy, act.done, act.illegal, e.s1, e.r_in, e.a_in, e.g_in, e.ir_in,
                    e.alu_op, e.busy, e.done, e.illegal);
`ifdef PROC_CTRL_INSTR_CNT_EN
      begin
        logic [15:0] ec;
        ec = cnt_q.pop_front();
        checks++;
        if (instr_cnt === ec) passes++;
        else $display("FAIL instr_cnt cycle=%0d got=%0d exp=%0d", cycle, instr_cnt, ec);
      end
`endif
    end
  end

  initial begin
    logic [15:0] ir;
    // reset held with run high: everything must stay at default
    cnt_model = 16'd0;
    do_cycle(1'b1, 1'b1, 16'h0000, '0);
    do_cycle(1'b1, 1'b0, 16'h4403, '0);
    idle_cycle();
    idle_cycle();

    // directed cases
    run_instr(16'b000_101_1_000010111, 1'b0);   // mvi R5,#23
    idle_cycle();
    run_instr(16'b001_010_0_010101011, 1'b0);   // mvt R2,#0xAB
    idle_cycle();
    run_instr(16'b010_001_0_000000011, 1'b0);   // add R1,R3
    idle_cycle();
    run_instr(16'b011_000_1_000000101, 1'b1);   // sub R0,#5 with run held
    run_instr(16'b100_011_0_000000011, 1'b1);   // and R3,R3 back-to-back
    run_instr(16'b111_001_0_000000001, 1'b0);   // illegal
    run_instr(16'b101_110_1_111111111, 1'b0);   // illegal
    idle_cycle();
    abort_instr(16'b010_001_0_000000011, 1);    // reset during T2 of add
    run_instr(16'b010_001_0_000000011, 1'b0);   // restarts cleanly
    idle_cycle();

    // randomized traffic
    for (int i = 0; i < 80; i++) begin
      ir = 16'($urandom);
      if ($urandom_range(0, 9) == 0) abort_instr(ir, $urandom_range(0, 2));
      else run_instr(ir, 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end
    idle_cycle();

    @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain left=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
Name: proc_ctrl_fsm

Overview:
- Control sequencer for the 16-bit simple processor. It sits directly upstream of the bus multiplexer and drives its 4-bit select.
- It also drives the register-file, A, G and IR load enables and the ALU operation.
- Each instruction is decoded from the IR into a T0..T3 timestep sequence, and `done` is pulsed on completion.

Parameters:
- SEL_W, 4, width of bus-mux select.
- SEL_G, 4'd8, select code for G register.
- SEL_D, 4'd9, select code for zero-extended immediate IR[8:0].
- SEL_DT, 4'd10, select code for IR[7:0]<<8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start request; sampled in T0 only.
- IR  in  16  instruction register contents (valid from T1).
- s1  out  SEL_W  bus-mux select.
- r_in  out  8  one-hot load enable for R0..R7.
- a_in  out  1  load A from bus.
- g_in  out  1  load G from ALU.
- ir_in  out  1  load IR from DIN.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 unused.
- busy  out  1  high in T1..T3.
- done  out  1  one-cycle pulse in the last step of an instruction.
- illegal  out  1  one-cycle pulse with done on an undefined opcode.

Behaviour:
- Instruction format:
  - IR[15:13] opcode.
  - IR[12:10] rX (destination).
  - IR[9] I flag (1 = immediate operand).
  - IR[8:0] immediate.
  - IR[2:0] rY when I=0.
- Opcodes: 0 mv, 1 mvt, 2 add, 3 sub, 4 and; 5..7 illegal.
- State register: T0, T1, T2, T3 (2-bit).
  - Reset forces T0 immediately, independent of the clock.
  - State transitions occur only on the rising clock edge.
- All outputs are combinational from state and IR (Moore within a step).
  - Default values: s1=0, every enable 0, alu_op=00, busy=0, done=0, illegal=0.
  - While reset is high, all outputs hold their default values.
- T0:
  - ir_in=run.
  - run=1 → next state T1; otherwise stay in T0.
- T1, by opcode:
  - mv: s1 = I ? SEL_D : rY; r_in[rX]=1; done=1; next T0.
  - mvt: s1=SEL_DT; r_in[rX]=1; done=1; next T0. The I flag is ignored.
  - add/sub/and: s1=rX; a_in=1; next T2.
  - illegal: done=1; illegal=1; no enables asserted; next T0.
- T2:
  - s1 = I ? SEL_D : rY; g_in=1; alu_op from opcode (2→00, 3→01, 4→10); next T3.
- T3:
  - s1=SEL_G; r_in[rX]=1; done=1; next T0.
- Latency, counted from the T0 cycle with run=1: mv, mvt and illegal finish in 2 cycles; ALU ops in 4 cycles. done is high in the final cycle.
- Run handling:
  - run is ignored outside T0 and is not queued.
  - If run is still high when the machine returns to T0, a new fetch starts immediately (back-to-back execution).
- r_in is strictly one-hot or zero, never multi-hot.
- rX=rY is legal (e.g. add R3,R3 doubles R3).
- Reset asserted in any state aborts the instruction. No done pulse is produced and no enable is asserted in that cycle.
- IR is treated as stable during T1..T3. This block never asserts ir_in outside T0.

Optional Feature:
- Macro: PROC_CTRL_INSTR_CNT_EN.
- Enabled:
  - Adds output instr_cnt[15:0].
  - The counter increments on every clock edge where done=1 and illegal=0.
  - Reset value 0; wraps 16'hFFFF→16'h0000.
- Disabled: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset during T2 of an add → state T0 at once; s1=0, r_in=0, g_in=0; no done; next run restarts from T0 cleanly.
- run=1 in T0 with IR=16'b000_101_1_000010111 (mvi R5,#23) → T0: ir_in=1; T1: s1=9, r_in=8'b0010_0000, done=1; back in T0.
- IR=16'b001_010_0_0_1010_1011 (mvt R2,#0xAB) → T1: s1=10, r_in=8'b0000_0100, done=1.
- IR=16'b010_001_0_000000011 (add R1,R3) → T1: s1=1, a_in=1; T2: s1=3, g_in=1, alu_op=00; T3: s1=8, r_in=8'b0000_0010, done=1.
- IR=16'b011_000_1_000000101 (sub R0,#5), with run held high throughout → T2: s1=9, alu_op=01; done in T3; a new ir_in asserted in the following T0 cycle.
- IR opcode 3'b111 → T1: done=1, illegal=1, all enables 0. With PROC_CTRL_INSTR_CNT_EN, instr_cnt is unchanged after the illegal op and incremented after each legal op; preloading 65535 and completing one legal op gives 0.
